// File: rtl/iir_coeff_loader_if.sv
// ---------------------------------------------------------------------------
// iir_coeff_loader_if
//   Host write channel into the IIR coefficient loader.
//
//   wr_valid  host -> loader   write request, held until accepted
//   wr_ready  loader -> host   write accept
//   wr_stage  host -> loader   target biquad stage index
//   wr_sel    host -> loader   coefficient select (0=a1 1=a2 2=b0 3=b1 4=b2)
//   wr_data   host -> loader   coefficient value
//
//   A write transfers on a clk edge where wr_valid and wr_ready are both 1.
// ---------------------------------------------------------------------------
interface iir_coeff_loader_if #(
  parameter int COEFF_SIZE = 16
) ();
  logic                  wr_valid;
  logic                  wr_ready;
  logic [7:0]            wr_stage;
  logic [2:0]            wr_sel;
  logic [COEFF_SIZE-1:0] wr_data;

  modport master (
    output wr_valid, wr_stage, wr_sel, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_stage, wr_sel, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/iir_coeff_loader.sv
// ---------------------------------------------------------------------------
// iir_coeff_loader
//   Double-buffered coefficient store for a cascade of biquad stages. The host
//   writes a shadow bank; a commit request arms a swap that copies the whole
//   shadow bank into the active bank on a filter sample boundary, so the filter
//   never sees a half-updated coefficient set.
//
// Ports
//   clk, rst_n       single clock, asynchronous active-low reset
//   wr               host write channel (iir_coeff_loader_if.slave)
//   commit_req       pulse: request shadow-to-active swap
//   sample_tick      pulse: filter sample boundary
//   busy             commit pending (ARMED or SWAP)
//   commit_done      pulse: swap completes on the edge ending this cycle
//   err_addr         sticky: a write hit an invalid stage/select
//   coeff_a1..b2     active coefficients, packed, stage 0 in the LSBs
//
// Configuration
//   IIR_COEFF_READBACK_EN  adds rd_stage/rd_sel/rd_data, a registered read
//                          port onto the active bank (0 for invalid address).
// ---------------------------------------------------------------------------
module iir_coeff_loader #(
  parameter int STAGE_CNT  = 8,
  parameter int COEFF_SIZE = 16,
  parameter int COEFF_FRAC = 14
) (
  input  logic                            clk,
  input  logic                            rst_n,
  iir_coeff_loader_if.slave               wr,
  input  logic                            commit_req,
  input  logic                            sample_tick,
  output logic                            busy,
  output logic                            commit_done,
  output logic                            err_addr,
  output logic [STAGE_CNT*COEFF_SIZE-1:0] coeff_a1,
  output logic [STAGE_CNT*COEFF_SIZE-1:0] coeff_a2,
  output logic [STAGE_CNT*COEFF_SIZE-1:0] coeff_b0,
  output logic [STAGE_CNT*COEFF_SIZE-1:0] coeff_b1,
  output logic [STAGE_CNT*COEFF_SIZE-1:0] coeff_b2
`ifdef IIR_COEFF_READBACK_EN
  ,
  input  logic [7:0]                      rd_stage,
  input  logic [2:0]                      rd_sel,
  output logic [COEFF_SIZE-1:0]           rd_data
`endif
);

  localparam int                    NUM_SEL   = 5;
  localparam logic [8:0]            STAGE_LIM = 9'(STAGE_CNT);
  localparam logic [COEFF_SIZE-1:0] UNITY     = COEFF_SIZE'(1) << COEFF_FRAC;

  // Bank layout: [select][stage][bit]; select order a1, a2, b0, b1, b2.
  typedef logic [NUM_SEL-1:0][STAGE_CNT-1:0][COEFF_SIZE-1:0] bank_t;

  typedef enum logic [1:0] {IDLE, ARMED, SWAP} state_t;

  // Pass-through biquad: b0 = 1.0, everything else 0.
  function automatic bank_t pass_bank();
    bank_t b;
    b = '0;
    for (int s = 0; s < STAGE_CNT; s++) b[2][s] = UNITY;
    return b;
  endfunction

  localparam bank_t PASS_BANK = pass_bank();

  state_t state_q, state_d;
  bank_t  shadow_q, shadow_d;
  bank_t  active_q, active_d;
  logic   wr_ready_q, wr_ready_d;
  logic   busy_q, busy_d;
  logic   commit_done_q, commit_done_d;
  logic   err_addr_q, err_addr_d;
  logic   wr_accept;
  logic   wr_ok;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    err_addr_d = err_addr_q;

    wr_accept = wr.wr_valid && wr_ready_q;
    wr_ok     = ({1'b0, wr.wr_stage} < STAGE_LIM) && (wr.wr_sel <= 3'd4);

    if (wr_accept && wr_ok) begin
      for (int c = 0; c < NUM_SEL; c++) begin
        for (int s = 0; s < STAGE_CNT; s++) begin
          if (wr.wr_sel == 3'(c) && wr.wr_stage == 8'(s)) shadow_d[c][s] = wr.wr_data;
        end
      end
    end

    // Accepting a commit clears the error, but a bad write in that very
    // cycle must still be reported.
    if (state_q == IDLE && commit_req) err_addr_d = wr_accept && !wr_ok;
    else if (wr_accept && !wr_ok)      err_addr_d = 1'b1;

    unique case (state_q)
      IDLE:    if (commit_req)  state_d = ARMED;  // same-cycle sample_tick ignored
      ARMED:   if (sample_tick) state_d = SWAP;
      SWAP: begin
        active_d = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    wr_ready_d    = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    commit_done_d = (state_d == SWAP);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: both coefficient banks are reset (not left uninitialised like a RAM)
  // so the filter sees a pass-through response straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shadow_q      <= PASS_BANK;
      active_q      <= PASS_BANK;
      wr_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      err_addr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      wr_ready_q    <= wr_ready_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign wr.wr_ready  = wr_ready_q;
  assign busy         = busy_q;
  assign commit_done  = commit_done_q;
  assign err_addr     = err_addr_q;
  assign coeff_a1     = active_q[0];
  assign coeff_a2     = active_q[1];
  assign coeff_b0     = active_q[2];
  assign coeff_b1     = active_q[3];
  assign coeff_b2     = active_q[4];

`ifdef IIR_COEFF_READBACK_EN
  logic [COEFF_SIZE-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < NUM_SEL; c++) begin
      for (int s = 0; s < STAGE_CNT; s++) begin
        if (rd_sel == 3'(c) && rd_stage == 8'(s)) rd_data_d = active_q[c][s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`else
  // Readback port absent in this build.
`endif

endmodule

// File: tb/tb_iir_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_iir_coeff_loader
//   Directed bench for iir_coeff_loader (STAGE_CNT=8, COEFF_SIZE=16,
//   COEFF_FRAC=14). Inputs change 1ns after a rising edge; outputs are
//   sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_iir_coeff_loader;

  localparam int STAGE_CNT  = 8;
  localparam int COEFF_SIZE = 16;
  localparam int COEFF_FRAC = 14;
  localparam int W          = STAGE_CNT * COEFF_SIZE;

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic         commit_req  = 1'b0;
  logic         sample_tick = 1'b0;
  logic         busy;
  logic         commit_done;
  logic         err_addr;
  logic [W-1:0] coeff_a1, coeff_a2, coeff_b0, coeff_b1, coeff_b2;

  iir_coeff_loader_if #(.COEFF_SIZE(COEFF_SIZE)) wr_if ();

`ifdef IIR_COEFF_READBACK_EN
  logic [7:0]            rd_stage = '0;
  logic [2:0]            rd_sel   = '0;
  logic [COEFF_SIZE-1:0] rd_data;
`endif

  iir_coeff_loader #(
    .STAGE_CNT (STAGE_CNT),
    .COEFF_SIZE(COEFF_SIZE),
    .COEFF_FRAC(COEFF_FRAC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if),
    .commit_req (commit_req),
    .sample_tick(sample_tick),
    .busy       (busy),
    .commit_done(commit_done),
    .err_addr   (err_addr),
    .coeff_a1   (coeff_a1),
    .coeff_a2   (coeff_a2),
    .coeff_b0   (coeff_b0),
    .coeff_b1   (coeff_b1),
    .coeff_b2   (coeff_b2)
`ifdef IIR_COEFF_READBACK_EN
    ,
    .rd_stage   (rd_stage),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cd_count    = 0;

  // Counts commit_done pulses as seen by the edge that ends them.
  always @(posedge clk) if (commit_done === 1'b1) cd_count++;

  // Expected banks, [select][stage]; select 0=a1 1=a2 2=b0 3=b1 4=b2.
  logic [COEFF_SIZE-1:0] exp_sh  [5][STAGE_CNT];
  logic [COEFF_SIZE-1:0] exp_act [5][STAGE_CNT];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] get_out(int c);
    case (c)
      0:       return coeff_a1;
      1:       return coeff_a2;
      2:       return coeff_b0;
      3:       return coeff_b1;
      default: return coeff_b2;
    endcase
  endfunction

  function automatic logic [W-1:0] pack_exp(int c);
    logic [W-1:0] v;
    for (int s = 0; s < STAGE_CNT; s++) v[s*COEFF_SIZE +: COEFF_SIZE] = exp_act[c][s];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < STAGE_CNT; s++) begin
        exp_sh[c][s]  = (c == 2) ? 16'h4000 : 16'h0000;
        exp_act[c][s] = (c == 2) ? 16'h4000 : 16'h0000;
      end
    end
  endtask

  // Waits (bounded) for wr_ready, transfers one write, updates the model.
  task automatic host_write(input logic [7:0] st, input logic [2:0] se, input logic [15:0] d);
    int n;
    wr_if.wr_stage = st;
    wr_if.wr_sel   = se;
    wr_if.wr_data  = d;
    wr_if.wr_valid = 1'b1;
    n = 0;
    while (wr_if.wr_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (wr_if.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL write_ready_timeout got %b exp 1", wr_if.wr_ready);
    end
    step();
    wr_if.wr_valid = 1'b0;
    if (st < STAGE_CNT && se <= 3'd4) exp_sh[se][st] = d;
  endtask

  // commit_req, then a sample_tick while ARMED, then the swap edge.
  task automatic do_swap();
    commit_req = 1'b1;
    step();
    commit_req  = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    exp_act = exp_sh;
  endtask

  task automatic test_reset();
    step();
    step();
    vectors++;
    if (wr_if.wr_ready !== 1'b0 || busy !== 1'b0 || commit_done !== 1'b0 || err_addr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got ready=%b busy=%b done=%b err=%b exp 0 0 0 0",
               wr_if.wr_ready, busy, commit_done, err_addr);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (wr_if.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_after_release got %b exp 1", wr_if.wr_ready);
    end
    vectors++;
    if (coeff_b0 !== {STAGE_CNT{16'h4000}}) begin
      miscompares++;
      $display("FAIL reset_b0 got %h exp %h", coeff_b0, {STAGE_CNT{16'h4000}});
    end
    vectors++;
    if ((coeff_a1 | coeff_a2 | coeff_b1 | coeff_b2) !== '0) begin
      miscompares++;
      $display("FAIL reset_others got a1=%h a2=%h b1=%h b2=%h exp 0", coeff_a1, coeff_a2, coeff_b1, coeff_b2);
    end
  endtask

  task automatic test_write_no_commit();
    int c0;
    host_write(8'd3, 3'd0, 16'hC123);
    for (int i = 0; i < 10; i++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
    end
    vectors++;
    if (coeff_a1[3*16 +: 16] !== 16'h0000) begin
      miscompares++;
      $display("FAIL nocommit_a1_3 got %h exp 0000", coeff_a1[3*16 +: 16]);
    end
    c0 = cd_count;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    vectors++;
    if (busy !== 1'b1 || wr_if.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL armed_flags got busy=%b ready=%b exp 1 0", busy, wr_if.wr_ready);
    end
    for (int i = 0; i < 4; i++) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    vectors++;
    if (commit_done !== 1'b1 || coeff_a1[3*16 +: 16] !== 16'h0000) begin
      miscompares++;
      $display("FAIL swap_edge1 got done=%b a1_3=%h exp 1 0000", commit_done, coeff_a1[3*16 +: 16]);
    end
    step();
    exp_act = exp_sh;
    vectors++;
    if (coeff_a1[3*16 +: 16] !== 16'hC123 || commit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL swap_edge2 got a1_3=%h done=%b exp C123 0", coeff_a1[3*16 +: 16], commit_done);
    end
    vectors++;
    if (busy !== 1'b0 || wr_if.wr_ready !== 1'b1 || cd_count !== c0 + 1) begin
      miscompares++;
      $display("FAIL swap_after got busy=%b ready=%b pulses=%0d exp 0 1 %0d", busy, wr_if.wr_ready, cd_count - c0, 1);
    end
  endtask

  task automatic test_armed_hold();
    commit_req = 1'b1;
    step();
    commit_req     = 1'b0;
    wr_if.wr_stage = 8'd0;
    wr_if.wr_sel   = 3'd4;
    wr_if.wr_data  = 16'h1234;
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_if.wr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL armed_ready_low cycle %0d got %b exp 0", i, wr_if.wr_ready);
      end
      step();
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    exp_act = exp_sh;
    vectors++;
    if (coeff_b2 !== pack_exp(4) || wr_if.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL armed_write_blocked got b2=%h ready=%b exp %h 1", coeff_b2, wr_if.wr_ready, pack_exp(4));
    end
    step();
    wr_if.wr_valid = 1'b0;
    exp_sh[4][0]   = 16'h1234;
    vectors++;
    if (coeff_b2 !== pack_exp(4)) begin
      miscompares++;
      $display("FAIL late_write_not_active got %h exp %h", coeff_b2, pack_exp(4));
    end
  endtask

  task automatic test_commit_with_write();
    wr_if.wr_stage = 8'd5;
    wr_if.wr_sel   = 3'd2;
    wr_if.wr_data  = 16'h2000;
    wr_if.wr_valid = 1'b1;
    commit_req     = 1'b1;
    step();
    wr_if.wr_valid = 1'b0;
    commit_req     = 1'b0;
    exp_sh[2][5]   = 16'h2000;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    exp_act = exp_sh;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (get_out(c) !== pack_exp(c)) begin
        miscompares++;
        $display("FAIL commit_with_write sel%0d got %h exp %h", c, get_out(c), pack_exp(c));
      end
    end
  endtask

  task automatic test_err_addr();
    host_write(8'd9, 3'd0, 16'h1111);
    vectors++;
    if (err_addr !== 1'b1) begin
      miscompares++;
      $display("FAIL err_bad_stage got %b exp 1", err_addr);
    end
    host_write(8'd2, 3'd5, 16'hFFFF);
    // Commit together with another invalid write: flag must stay set.
    wr_if.wr_stage = 8'd8;
    wr_if.wr_sel   = 3'd0;
    wr_if.wr_data  = 16'hAAAA;
    wr_if.wr_valid = 1'b1;
    commit_req     = 1'b1;
    step();
    wr_if.wr_valid = 1'b0;
    commit_req     = 1'b0;
    vectors++;
    if (err_addr !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err_kept_on_bad_commit got err=%b busy=%b exp 1 1", err_addr, busy);
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    exp_act = exp_sh;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (get_out(c) !== pack_exp(c)) begin
        miscompares++;
        $display("FAIL err_no_shadow_change sel%0d got %h exp %h", c, get_out(c), pack_exp(c));
      end
    end
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    vectors++;
    if (err_addr !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear_on_commit got %b exp 0", err_addr);
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
  endtask

  task automatic test_commit_tick_same();
    host_write(8'd1, 3'd3, 16'h0ABC);
    commit_req  = 1'b1;
    sample_tick = 1'b1;
    step();
    commit_req  = 1'b0;
    sample_tick = 1'b0;
    step();
    step();
    vectors++;
    if (busy !== 1'b1 || commit_done !== 1'b0 || coeff_b1 !== pack_exp(3)) begin
      miscompares++;
      $display("FAIL same_cycle_tick_ignored got busy=%b done=%b b1=%h exp 1 0 %h", busy, commit_done, coeff_b1, pack_exp(3));
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    vectors++;
    if (commit_done !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cycle_next_tick got done=%b exp 1", commit_done);
    end
    step();
    exp_act = exp_sh;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (get_out(c) !== pack_exp(c)) begin
        miscompares++;
        $display("FAIL same_cycle_swap sel%0d got %h exp %h", c, get_out(c), pack_exp(c));
      end
    end
  endtask

  task automatic test_reset_abort();
    int c0;
    host_write(8'd6, 3'd1, 16'h5555);
    c0 = cd_count;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    rst_n      = 1'b0;
    #2;
    model_reset();
    vectors++;
    if (busy !== 1'b0 || wr_if.wr_ready !== 1'b0 || coeff_b0 !== pack_exp(2) || coeff_b1 !== '0) begin
      miscompares++;
      $display("FAIL abort_async got busy=%b ready=%b b0=%h b1=%h exp 0 0 %h 0", busy, wr_if.wr_ready, coeff_b0, coeff_b1, pack_exp(2));
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (get_out(c) !== pack_exp(c)) begin
        miscompares++;
        $display("FAIL abort_passthrough sel%0d got %h exp %h", c, get_out(c), pack_exp(c));
      end
    end
    vectors++;
    if (cd_count !== c0 || busy !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_no_done got pulses=%0d busy=%b ready=%b exp 0 0 1", cd_count - c0, busy, wr_if.wr_ready);
    end
  endtask

  task automatic test_back_to_back();
    wr_if.wr_stage = 8'd0;
    wr_if.wr_sel   = 3'd0;
    wr_if.wr_data  = 16'h0101;
    wr_if.wr_valid = 1'b1;
    vectors++;
    if (wr_if.wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready got %b exp 1", wr_if.wr_ready);
    end
    step();
    exp_sh[0][0]   = 16'h0101;
    wr_if.wr_stage = 8'd7;
    wr_if.wr_sel   = 3'd4;
    wr_if.wr_data  = 16'h7FFF;
    step();
    wr_if.wr_valid = 1'b0;
    exp_sh[4][7]   = 16'h7FFF;
    do_swap();
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (get_out(c) !== pack_exp(c)) begin
        miscompares++;
        $display("FAIL b2b_swap sel%0d got %h exp %h", c, get_out(c), pack_exp(c));
      end
    end
`ifdef IIR_COEFF_READBACK_EN
    rd_stage = 8'd7;
    rd_sel   = 3'd4;
    step();
    vectors++;
    if (rd_data !== 16'h7FFF) begin
      miscompares++;
      $display("FAIL readback_valid got %h exp 7FFF", rd_data);
    end
    rd_sel = 3'd6;
    step();
    vectors++;
    if (rd_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL readback_invalid got %h exp 0000", rd_data);
    end
`endif
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_stage = '0;
    wr_if.wr_sel   = '0;
    wr_if.wr_data  = '0;
    model_reset();
    #1;
    test_reset();
    test_write_no_commit();
    test_armed_hold();
    test_commit_with_write();
    test_err_addr();
    test_commit_tick_same();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
